// File: rtl/mux_rr_arbiter_if.sv
// Request/grant bundle between the four mux requesters and the
// round-robin arbiter that drives the shared 4:1 mux select.
// Handshake: req[i] is a level request from requester i.
// gnt is a registered one-hot grant, or zero when there is no owner.
// A requester owns the mux for every cycle in which its gnt bit is high.
// sel carries the owner index and is meaningful whenever gnt_valid is 1.
interface mux_rr_arbiter_if;
   logic [3:0] req;
   logic [3:0] gnt;
   logic [1:0] sel;
   logic       gnt_valid;
   logic       dbg_state;   // arbiter FSM state: 0 = IDLE, 1 = GRANT

   // requester side
   modport master (
      output req,
      input  gnt, sel, gnt_valid, dbg_state
   );

   // arbiter side
   modport slave (
      input  req,
      output gnt, sel, gnt_valid, dbg_state
   );
endinterface

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter and select controller for a shared 4:1 mux.
// The owner keeps the grant while it requests, for up to MAX_HOLD cycles
// when others are waiting, and then the grant rotates. The owner is the
// last requester scanned, so a waiting requester is never starved.
module mux_rr_arbiter #(
   parameter int MAX_HOLD = 8
) (
   input logic             clk,
   input logic             rst_n,
   mux_rr_arbiter_if.slave bus
);

   localparam int HW = $clog2(MAX_HOLD + 1);
   localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD);
   localparam logic [HW-1:0] HOLD_ONE = HW'(1);

   typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

   state_t        state_q, state_d;
   logic [3:0]    gnt_q, gnt_d;
   logic [1:0]    sel_q, sel_d;
   logic [1:0]    ptr_q, ptr_d;
   logic [HW-1:0] hold_q, hold_d;

   logic          win_found;
   logic [1:0]    win_idx;
   logic [1:0]    cand;
   logic          others;

   // Round-robin scan from ptr_q+1 to ptr_q+4; the previous winner comes last.
   always_comb begin
      win_found = 1'b0;
      win_idx   = ptr_q;
      cand      = ptr_q;
      for (int i = 1; i <= 4; i++) begin
         cand = ptr_q + 2'(i);
         if (!win_found && bus.req[cand]) begin
            win_found = 1'b1;
            win_idx   = cand;
         end
      end
   end

   assign others = |(bus.req & ~gnt_q);

   // Next-state logic: keep, rotate, switch on release, or drop to IDLE.
   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      sel_d   = sel_q;
      ptr_d   = ptr_q;
      hold_d  = hold_q;
      case (state_q)
         IDLE: begin
            if (win_found) begin
               state_d = GRANT;
               gnt_d   = 4'b0001 << win_idx;
               sel_d   = win_idx;
               ptr_d   = win_idx;
               hold_d  = HOLD_ONE;
            end
         end
         GRANT: begin
            if (bus.req[sel_q] && ((hold_q < HOLD_MAX) || !others)) begin
               if (hold_q < HOLD_MAX) begin
                  hold_d = hold_q + HOLD_ONE;
               end
            end else if (others) begin
               // Another requester is pending, so the scan finds a winner
               // other than the current owner.
               gnt_d  = 4'b0001 << win_idx;
               sel_d  = win_idx;
               ptr_d  = win_idx;
               hold_d = HOLD_ONE;
            end else begin
               state_d = IDLE;
               gnt_d   = 4'b0000;
               hold_d  = '0;
            end
         end
         default: begin
            state_d = IDLE;
            gnt_d   = 4'b0000;
            hold_d  = '0;
         end
      endcase
   end

   // State registers with synchronous active-low reset; requester 0 is first.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         gnt_q   <= 4'b0000;
         sel_q   <= 2'd0;
         ptr_q   <= 2'd3;
         hold_q  <= '0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         sel_q   <= sel_d;
         ptr_q   <= ptr_d;
         hold_q  <= hold_d;
      end
   end

   assign bus.gnt       = gnt_q;
   assign bus.sel       = sel_q;
   assign bus.gnt_valid = |gnt_q;
   assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed bench for mux_rr_arbiter: one MAX_HOLD=8 instance and one
// MAX_HOLD=1 instance. Expected grants are worked out by hand.
module tb_mux_rr_arbiter;

   logic clk;
   logic rst_n;
   int   vectors;
   int   miscompares;

   mux_rr_arbiter_if ifc8();
   mux_rr_arbiter_if ifc1();

   mux_rr_arbiter #(.MAX_HOLD(8)) u_dut8 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (ifc8.slave)
   );

   mux_rr_arbiter #(.MAX_HOLD(1)) u_dut1 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (ifc1.slave)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one rising edge and settle before checking outputs.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk8(input string tag, input logic [3:0] g, input logic [1:0] s,
                       input logic v);
      vectors++;
      assert (ifc8.gnt === g && ifc8.sel === s && ifc8.gnt_valid === v &&
              ifc8.dbg_state === v)
      else begin
         miscompares++;
         $error("FAIL %s: gnt=%b sel=%0d valid=%b state=%b, expected gnt=%b sel=%0d valid=%b state=%b",
                tag, ifc8.gnt, ifc8.sel, ifc8.gnt_valid, ifc8.dbg_state, g, s, v, v);
      end
   endtask

   task automatic chk1(input string tag, input logic [3:0] g, input logic [1:0] s,
                       input logic v);
      vectors++;
      assert (ifc1.gnt === g && ifc1.sel === s && ifc1.gnt_valid === v &&
              ifc1.dbg_state === v)
      else begin
         miscompares++;
         $error("FAIL %s: gnt=%b sel=%0d valid=%b state=%b, expected gnt=%b sel=%0d valid=%b state=%b",
                tag, ifc1.gnt, ifc1.sel, ifc1.gnt_valid, ifc1.dbg_state, g, s, v, v);
      end
   endtask

   initial begin
      logic [3:0] g;
      vectors     = 0;
      miscompares = 0;
      rst_n       = 1'b0;
      ifc8.req    = 4'b1111;
      ifc1.req    = 4'b0000;

      // 1. reset held 2 cycles with every requester active
      step();
      chk8("rst_c1", 4'b0000, 2'd0, 1'b0);
      chk1("rst1_c1", 4'b0000, 2'd0, 1'b0);
      step();
      chk8("rst_c2", 4'b0000, 2'd0, 1'b0);
      rst_n = 1'b1;
      step();
      chk8("rst_release", 4'b0001, 2'd0, 1'b1);
      chk1("rst1_idle", 4'b0000, 2'd0, 1'b0);

      // 3. full contention: each owner holds exactly 8 cycles, order 0,1,2,3,0
      for (int k = 0; k < 7; k++) begin
         step();
         chk8("hold0", 4'b0001, 2'd0, 1'b1);
      end
      for (int o = 1; o <= 4; o++) begin
         g = 4'b0001 << (o % 4);
         step();
         chk8("rotate", g, 2'(o % 4), 1'b1);
         if (o < 4) begin
            for (int k = 0; k < 7; k++) begin
               step();
               chk8("hold", g, 2'(o), 1'b1);
            end
         end
      end

      // 4. early release: owner 0 lets go on its third cycle, no idle bubble
      ifc8.req = 4'b0011;
      step();
      chk8("early_c2", 4'b0001, 2'd0, 1'b1);
      step();
      chk8("early_c3", 4'b0001, 2'd0, 1'b1);
      ifc8.req = 4'b0010;
      step();
      chk8("early_switch", 4'b0010, 2'd1, 1'b1);

      // 2. single requester keeps the grant well past MAX_HOLD
      ifc8.req = 4'b0100;
      step();
      chk8("single_grant", 4'b0100, 2'd2, 1'b1);
      for (int k = 0; k < 20; k++) begin
         step();
         chk8("single_hold", 4'b0100, 2'd2, 1'b1);
      end
      ifc8.req = 4'b0000;
      step();
      chk8("single_drop", 4'b0000, 2'd2, 1'b0);
      step();
      chk8("idle_keep_sel", 4'b0000, 2'd2, 1'b0);

      // 5. fairness with wrap-around; req changes on the expiry cycle itself
      ifc8.req = 4'b1000;
      step();
      chk8("own3_grant", 4'b1000, 2'd3, 1'b1);
      for (int k = 0; k < 7; k++) begin
         step();
         chk8("own3_hold", 4'b1000, 2'd3, 1'b1);
      end
      ifc8.req = 4'b1001;
      step();
      chk8("wrap_to0", 4'b0001, 2'd0, 1'b1);
      for (int k = 0; k < 7; k++) begin
         step();
         chk8("own0_hold", 4'b0001, 2'd0, 1'b1);
      end
      step();
      chk8("expire_to3", 4'b1000, 2'd3, 1'b1);

      // 6. reset in the middle of a grant to requester 2
      ifc8.req = 4'b0100;
      step();
      chk8("pre_rst_own2", 4'b0100, 2'd2, 1'b1);
      step();
      chk8("pre_rst_hold2", 4'b0100, 2'd2, 1'b1);
      rst_n = 1'b0;
      step();
      chk8("mid_rst", 4'b0000, 2'd0, 1'b0);
      rst_n    = 1'b1;
      ifc8.req = 4'b0110;
      step();
      chk8("post_rst", 4'b0010, 2'd1, 1'b1);

      // MAX_HOLD=1: with several requesters the grant rotates every cycle
      ifc1.req = 4'b1111;
      step();
      chk1("mh1_g0", 4'b0001, 2'd0, 1'b1);
      step();
      chk1("mh1_g1", 4'b0010, 2'd1, 1'b1);
      step();
      chk1("mh1_g2", 4'b0100, 2'd2, 1'b1);
      step();
      chk1("mh1_g3", 4'b1000, 2'd3, 1'b1);
      step();
      chk1("mh1_wrap", 4'b0001, 2'd0, 1'b1);
      ifc1.req = 4'b0101;
      step();
      chk1("mh1_to2", 4'b0100, 2'd2, 1'b1);
      step();
      chk1("mh1_to0", 4'b0001, 2'd0, 1'b1);
      ifc1.req = 4'b0001;
      step();
      chk1("mh1_alone", 4'b0001, 2'd0, 1'b1);

      // final report
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
